// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants.
package gray_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Binary to reflected Gray code; narrower values are zero-extended by callers.
  function automatic logic [31:0] bin2gray(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits from the MSB down.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter, shared with the CDC pointer synchroniser.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Prefix XOR from the MSB down.
  always_comb begin
    bin_o = '0;
    bin_o[WIDTH-1] = gray_i[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray counter with wrap or saturate at the bounds and
// synchronous load from a binary or Gray value. bin and gray are both
// registered and updated on the same edge, so gray always encodes bin.
module gray_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int          SATURATE = MODE_WRAP,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] load_bin;

  gray2bin #(.WIDTH(WIDTH)) u_load_conv (
    .gray_i (load_val),
    .bin_o  (load_bin)
  );

  // Next count and flags: load beats step, step beats hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (load) begin
      bin_d = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX_VAL) begin
          if (SAT_MODE) begin
            sat_d = 1'b1;
          end else begin
            bin_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == '0) begin
          if (SAT_MODE) begin
            sat_d = 1'b1;
          end else begin
            bin_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - WIDTH'(1);
        end
      end
    end
    gray_d = WIDTH'(bin2gray(32'(bin_d)));
  end

  // Output registers; gray is registered from the encoded next count so it never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised, registered Gray-code counter; the sequential successor to the combinational binary-to-Gray converter.
- Counts up or down in binary internally and publishes the binary and Gray values from registers, so the Gray output changes exactly one bit per step and never glitches.
- Used for FIFO pointers, rotary/position tracking and any count that crosses a clock domain.
- Supports wrap or saturate mode and synchronous load from either binary or Gray input.

Parameters:
- WIDTH, 4, counter width in bits (legal 2..32).
- SATURATE, 0, 0 = wrap at the bounds, 1 = hold at the bounds.
- RST_VAL, 0, binary count value after reset (must be < 2^WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  step enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load request.
- load_is_gray  input  1  1 = load_val is Gray-coded, 0 = load_val is binary.
- load_val  input  WIDTH  value to load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray count, equal to bin ^ (bin >> 1).
- wrap  output  1  registered one-cycle pulse after a wrap step.
- sat  output  1  registered one-cycle pulse after a step suppressed at a bound.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - bin = RST_VAL, gray = RST_VAL ^ (RST_VAL >> 1), wrap = 0, sat = 0.
  - Release is synchronous to the next clk edge. Reset asserted mid-count discards the current count.
- Priority per rising edge: load > en > hold.
- Load (load = 1, regardless of en or up):
  - next_bin = load_is_gray ? gray2bin(load_val) : load_val.
  - The Gray output is recomputed from next_bin. wrap = 0, sat = 0.
  - A Gray load value is never passed through unconverted; gray always equals the encoding of bin.
- Step (load = 0, en = 1):
  - up = 1 and bin < MAX (MAX = 2^WIDTH - 1): bin + 1.
  - up = 0 and bin > 0: bin - 1.
  - Step up at bin = MAX:
    - SATURATE = 0: next_bin = 0, wrap = 1.
    - SATURATE = 1: bin holds, sat = 1.
  - Step down at bin = 0:
    - SATURATE = 0: next_bin = MAX, wrap = 1.
    - SATURATE = 1: bin holds, sat = 1.
- Hold (load = 0, en = 0): all registers keep their value; wrap = 0, sat = 0.
- Arithmetic is modulo 2^WIDTH; there is no carry-out other than wrap.
- Latency:
  - Inputs sampled at edge N appear on bin, gray, wrap and sat after edge N.
  - bin and gray update on the same edge; there is no cycle where gray does not encode bin.
- Gray property: every enabled non-saturated step changes exactly one gray bit, including the wrap step (MAX <-> 0 differs only in the MSB).
- Simultaneous load and en: load wins and no step occurs.
- Direction change between consecutive steps is allowed with no dead cycle.
- wrap and sat are never both 1. Each is high only in the cycle following the causing edge.

Decomposition:
- Shared package gray_pkg:
  - function bin2gray(x) = x ^ (x >> 1).
  - function gray2bin (prefix XOR from the MSB down).
  - localparam mode constants MODE_WRAP = 0, MODE_SAT = 1.
- One sub-module gray2bin (parametrised WIDTH, combinational) converts load_val for Gray loads. It is reused later by the CDC pointer synchroniser.
- The counter datapath, wrap/sat flags and output registers stay in gray_counter.

Test Plan:
- Reset, WIDTH=4, RST_VAL=0: hold rst_n low, then release -> bin = 0000, gray = 0000, wrap = sat = 0. Assert rst_n low mid-count at bin = 0110 -> outputs return to 0 immediately, without waiting for clk.
- Full up sweep, WRAP: en = 1, up = 1 for 17 cycles -> gray sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000 with wrap = 1 for exactly one cycle. Check every step for a single-bit Hamming distance.
- Down wrap and direction change: from bin = 0001, step up = 0 twice -> 0000, then 1111 (gray 1000) with wrap = 1. Set up = 1 on the next cycle -> 0000, wrap = 1.
- Saturate, SATURATE=1: at bin = 1111, en = 1, up = 1 -> bin holds at 1111 and sat pulses for one cycle. At bin = 0000, step down -> holds, sat = 1, wrap = 0.
- Loads:
  - load = 1, load_is_gray = 0, load_val = 1010 -> bin = 1010, gray = 1111.
  - load_is_gray = 1, load_val = 1010 -> bin = 1100, gray = 1010.
  - load = 1 together with en = 1, up = 1 -> the loaded value wins with no increment.
- Hold: en = 0 for 5 cycles at bin = 0101 -> bin, gray and flags stay constant (gray = 0111, wrap = sat = 0).
